// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: frame layout, controller states and
// default geometry constants.
package cpu_types_pkg;

   localparam int ICACHE_WORD_W    = 32;
   localparam int ICACHE_SETS      = 16;
   localparam int ICACHE_IDX_W     = $clog2(ICACHE_SETS);
   localparam int ICACHE_TAG_W     = ICACHE_WORD_W - 2 - ICACHE_IDX_W;
   // Widest tag any legal geometry can need (SETS = 2); narrower tags are zero-extended.
   localparam int ICACHE_TAG_MAX_W = ICACHE_WORD_W - 3;

   typedef struct packed {
      logic                        valid;
      logic [ICACHE_TAG_MAX_W-1:0] tag;
      logic [ICACHE_WORD_W-1:0]    data;
   } icache_frame_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits return in the same
// cycle; misses fetch a single word from memory_control and then hit.
module icache
   import cpu_types_pkg::*;
#(
   parameter int SETS   = ICACHE_SETS,
   parameter int WORD_W = ICACHE_WORD_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic [WORD_W-1:0] imemload,
   output logic              ihit,
   input  logic              iflush,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic [WORD_W-1:0] iload,
   input  logic              iwait
);

   localparam int IDX_W = $clog2(SETS);

   // Memory handshake: iREN/iaddr are held steady for the whole of FETCH; the
   // transfer completes on the first rising edge where iwait=0, and iload is
   // captured on that same edge. iREN drops the cycle after completion or abort.

   icache_state_e              state;
   logic [WORD_W-1:0]          miss_addr;
   icache_frame_t              frames [SETS];

   logic [IDX_W-1:0]            req_idx;
   logic [IDX_W-1:0]            miss_idx;
   logic [ICACHE_TAG_MAX_W-1:0] req_tag;
   logic [ICACHE_TAG_MAX_W-1:0] miss_tag;
   logic                        lookup_hit;
   logic                        same_addr;

   assign req_idx  = imemaddr[IDX_W+1:2];
   assign miss_idx = miss_addr[IDX_W+1:2];
   assign req_tag  = ICACHE_TAG_MAX_W'(imemaddr[WORD_W-1:IDX_W+2]);
   assign miss_tag = ICACHE_TAG_MAX_W'(miss_addr[WORD_W-1:IDX_W+2]);
   assign same_addr = (imemaddr == miss_addr);

   assign lookup_hit = (state == IDLE) && imemREN &&
                       frames[req_idx].valid && (frames[req_idx].tag == req_tag);

   // A flush in the same cycle masks the hit so the datapath never consumes a
   // word from a frame that is about to be invalidated.
   assign ihit     = lookup_hit && !iflush;
   assign imemload = ihit ? frames[req_idx].data : '0;

   assign iREN  = (state == FETCH);
   assign iaddr = (state == FETCH) ? {miss_addr[WORD_W-1:2], 2'b00} : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         miss_addr <= '0;
         for (int i = 0; i < SETS; i++) begin
            frames[i].valid <= 1'b0;
         end
      end else if (iflush) begin
         state <= IDLE;
         for (int i = 0; i < SETS; i++) begin
            frames[i].valid <= 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (imemREN && !lookup_hit) begin
                  miss_addr <= imemaddr;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               // A completed transfer always fills, even if the datapath has moved on.
               if (!iwait) begin
                  frames[miss_idx].valid <= 1'b1;
                  frames[miss_idx].tag   <= miss_tag;
                  frames[miss_idx].data  <= iload;
                  state                  <= IDLE;
               end else if (!imemREN || !same_addr) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_icache;

   localparam int SETS = 16;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        ihit;
   logic        iflush;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;

   int vectors;
   int miscompares;

   icache #(.SETS(SETS), .WORD_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
      .iflush(iflush), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct packed {
      logic        ren;
      logic [31:0] addr;
      logic        flush;
      logic        stall;
      logic [31:0] load;
      logic        e_hit;
      logic [31:0] e_load;
      logic        e_ren;
      logic [31:0] e_iaddr;
   } vec_t;

   vec_t vtab [23];

   function automatic vec_t mk(logic ren, logic [31:0] addr, logic flush, logic stall,
                               logic [31:0] load, logic e_hit, logic [31:0] e_load,
                               logic e_ren, logic [31:0] e_iaddr);
      vec_t v;
      v.ren = ren; v.addr = addr; v.flush = flush; v.stall = stall; v.load = load;
      v.e_hit = e_hit; v.e_load = e_load; v.e_ren = e_ren; v.e_iaddr = e_iaddr;
      return v;
   endfunction

   // scoreboard
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic e_hit, input logic [31:0] e_load,
                          input logic e_ren, input logic [31:0] e_iaddr);
      chk({name, ".ihit"},     32'(ihit),  32'(e_hit));
      chk({name, ".imemload"}, imemload,   e_load);
      chk({name, ".iREN"},     32'(iREN),  32'(e_ren));
      chk({name, ".iaddr"},    iaddr,      e_iaddr);
   endtask

   // drivers
   task automatic drive(input logic ren, input logic [31:0] addr, input logic flush,
                        input logic stall, input logic [31:0] load);
      imemREN = ren; imemaddr = addr; iflush = flush; iwait = stall; iload = load;
   endtask

   task automatic cyc(input string name, input logic e_hit, input logic [31:0] e_load,
                      input logic e_ren, input logic [31:0] e_iaddr);
      @(negedge CLK);
      chk_all(name, e_hit, e_load, e_ren, e_iaddr);
      @(posedge CLK);
      #1;
   endtask

   // reference model: cache contents by index, plus the outstanding fetch
   logic        m_valid [SETS];
   logic [31:0] m_addr  [SETS];
   logic [31:0] m_data  [SETS];
   logic        m_pend;
   logic [31:0] m_paddr;
   logic [65:0] exp_q [$];

   initial begin
      logic [31:0] pool [8];
      logic [65:0] e;
      int          idx;
      logic        e_hit;

      vectors = 0;
      miscompares = 0;
      nRST = 1'b0;
      drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);

      // reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      @(posedge CLK);
      #1;

      // cold miss, warm hit, eviction, flush
      vtab[0]  = mk(1, 32'h40, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
      vtab[1]  = mk(1, 32'h40, 0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
      vtab[2]  = mk(1, 32'h40, 0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
      vtab[3]  = mk(1, 32'h40, 0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
      vtab[4]  = mk(1, 32'h40, 0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40);
      vtab[5]  = mk(1, 32'h40, 0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
      vtab[6]  = mk(0, 32'h40, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
      vtab[7]  = mk(1, 32'h80, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
      vtab[8]  = mk(1, 32'h80, 0, 0, 32'h11111111, 0, 32'h0,        1, 32'h80);
      vtab[9]  = mk(1, 32'h80, 0, 1, 32'h0,        1, 32'h11111111, 0, 32'h0);
      vtab[10] = mk(1, 32'h40, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
      vtab[11] = mk(1, 32'h40, 0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40);
      vtab[12] = mk(1, 32'h40, 0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
      vtab[13] = mk(1, 32'h48, 0, 0, 32'hCAFEF00D, 0, 32'h0,        0, 32'h0);
      vtab[14] = mk(1, 32'h48, 0, 0, 32'hCAFEF00D, 0, 32'h0,        1, 32'h48);
      vtab[15] = mk(1, 32'h48, 0, 1, 32'h0,        1, 32'hCAFEF00D, 0, 32'h0);
      vtab[16] = mk(1, 32'h40, 0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
      vtab[17] = mk(0, 32'h0,  1, 1, 32'h0,        0, 32'h0,        0, 32'h0);
      vtab[18] = mk(1, 32'h48, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
      vtab[19] = mk(0, 32'h48, 0, 1, 32'h0,        0, 32'h0,        1, 32'h48);
      vtab[20] = mk(1, 32'h40, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
      vtab[21] = mk(1, 32'h40, 1, 1, 32'h0,        0, 32'h0,        1, 32'h40);
      vtab[22] = mk(0, 32'h0,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);

      for (int i = 0; i < 23; i++) begin
         drive(vtab[i].ren, vtab[i].addr, vtab[i].flush, vtab[i].stall, vtab[i].load);
         cyc($sformatf("vec%0d", i), vtab[i].e_hit, vtab[i].e_load, vtab[i].e_ren,
             vtab[i].e_iaddr);
      end

      // abort by dropping the request, then the same address misses again
      drive(1, 32'h44, 0, 1, 32'h0);        cyc("abort_miss",   0, 32'h0, 0, 32'h0);
      drive(0, 32'h44, 0, 1, 32'h0);        cyc("abort_fetch",  0, 32'h0, 1, 32'h44);
      drive(0, 32'h44, 0, 1, 32'h0);        cyc("abort_idle",   0, 32'h0, 0, 32'h0);
      drive(1, 32'h44, 0, 1, 32'h0);        cyc("abort_remiss", 0, 32'h0, 0, 32'h0);
      drive(1, 32'h44, 0, 0, 32'hAAAA0044); cyc("abort_fill",   0, 32'h0, 1, 32'h44);
      drive(1, 32'h44, 0, 1, 32'h0);        cyc("abort_hit",    1, 32'hAAAA0044, 0, 32'h0);

      // abort by address change
      drive(1, 32'h4C, 0, 1, 32'h0);        cyc("chg_miss",     0, 32'h0, 0, 32'h0);
      drive(1, 32'h50, 0, 1, 32'h0);        cyc("chg_fetch",    0, 32'h0, 1, 32'h4C);
      drive(1, 32'h4C, 0, 1, 32'h0);        cyc("chg_remiss",   0, 32'h0, 0, 32'h0);
      drive(0, 32'h4C, 0, 1, 32'h0);        cyc("chg_drop",     0, 32'h0, 1, 32'h4C);

      // completed fetch fills even though the request address moved
      drive(1, 32'h54, 0, 1, 32'h0);        cyc("mv_miss",      0, 32'h0, 0, 32'h0);
      drive(1, 32'h58, 0, 0, 32'hBBBB0054); cyc("mv_fill",      0, 32'h0, 1, 32'h54);
      drive(1, 32'h54, 0, 1, 32'h0);        cyc("mv_hit",       1, 32'hBBBB0054, 0, 32'h0);

      // flush on the completion edge: no fill, and earlier frames gone
      drive(1, 32'h5C, 0, 1, 32'h0);        cyc("fl_miss",      0, 32'h0, 0, 32'h0);
      drive(1, 32'h5C, 1, 0, 32'hCCCC005C); cyc("fl_fetch",     0, 32'h0, 1, 32'h5C);
      drive(1, 32'h5C, 0, 1, 32'h0);        cyc("fl_5c_miss",   0, 32'h0, 0, 32'h0);
      drive(0, 32'h5C, 0, 1, 32'h0);        cyc("fl_5c_drop",   0, 32'h0, 1, 32'h5C);
      drive(1, 32'h54, 0, 1, 32'h0);        cyc("fl_54_miss",   0, 32'h0, 0, 32'h0);
      drive(1, 32'h54, 0, 0, 32'hDDDD0054); cyc("fl_54_fill",   0, 32'h0, 1, 32'h54);
      drive(1, 32'h54, 1, 1, 32'h0);        cyc("fl_hold",      0, 32'h0, 0, 32'h0);
      drive(1, 32'h54, 0, 1, 32'h0);        cyc("fl_54_gone",   0, 32'h0, 0, 32'h0);
      drive(0, 32'h54, 0, 1, 32'h0);        cyc("fl_54_drop",   0, 32'h0, 1, 32'h54);

      // reset during FETCH
      drive(1, 32'h64, 0, 1, 32'h0);        cyc("rst_64_miss",  0, 32'h0, 0, 32'h0);
      drive(1, 32'h64, 0, 0, 32'hEEEE0064); cyc("rst_64_fill",  0, 32'h0, 1, 32'h64);
      drive(1, 32'h60, 0, 1, 32'h0);        cyc("rst_60_miss",  0, 32'h0, 0, 32'h0);
      drive(1, 32'h60, 0, 0, 32'hFFFF0060);
      chk("rst_pre.iREN", 32'(iREN), 32'h1);
      nRST = 1'b0;
      #1;
      chk_all("rst_async", 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      drive(1, 32'h60, 0, 1, 32'h0);        cyc("rst_60_again", 0, 32'h0, 0, 32'h0);
      drive(0, 32'h60, 0, 1, 32'h0);        cyc("rst_60_drop",  0, 32'h0, 1, 32'h60);
      drive(1, 32'h64, 0, 1, 32'h0);        cyc("rst_64_gone",  0, 32'h0, 0, 32'h0);
      drive(0, 32'h64, 0, 1, 32'h0);        cyc("rst_64_drop",  0, 32'h0, 1, 32'h64);

      // randomized traffic; the cache is empty and idle here
      pool[0] = 32'h40;       pool[1] = 32'h80;       pool[2] = 32'hC0;
      pool[3] = 32'h44;       pool[4] = 32'h84;       pool[5] = 32'h48;
      pool[6] = 32'h1000_0048; pool[7] = 32'hFFFF_FFFC;
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
      end
      m_pend = 1'b0;
      m_paddr = '0;

      for (int n = 0; n < 600; n++) begin
         imemREN  = ($urandom_range(0, 9) < 8);
         imemaddr = (m_pend && $urandom_range(0, 9) < 7) ? m_paddr : pool[$urandom_range(0, 7)];
         iwait    = ($urandom_range(0, 9) < 6);
         iflush   = ($urandom_range(0, 29) == 0);
         iload    = $urandom;

         idx   = int'((imemaddr >> 2) % SETS);
         e_hit = !m_pend && imemREN && !iflush && m_valid[idx] && (m_addr[idx] == imemaddr);
         exp_q.push_back({e_hit, e_hit ? m_data[idx] : 32'h0, m_pend,
                          m_pend ? m_paddr : 32'h0});

         @(negedge CLK);
         e = exp_q.pop_front();
         chk_all($sformatf("rnd%0d", n), e[65], e[64:33], e[32], e[31:0]);

         if (iflush) begin
            for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
            m_pend = 1'b0;
         end else if (m_pend) begin
            if (!iwait) begin
               idx = int'((m_paddr >> 2) % SETS);
               m_valid[idx] = 1'b1;
               m_addr[idx]  = m_paddr;
               m_data[idx]  = iload;
               m_pend       = 1'b0;
            end else if (!imemREN || imemaddr != m_paddr) begin
               m_pend = 1'b0;
            end
         end else if (imemREN && !e_hit) begin
            m_pend  = 1'b1;
            m_paddr = imemaddr;
         end
         @(posedge CLK);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
